// File: rtl/tpdf_requantizer.sv
`default_nettype none
// ============================================================================
//  Module   : tpdf_requantizer
//  Purpose  : TPDF-dithered, optionally noise-shaped requantizer, IN_BITS to OUT_BITS
//  Revision : 1.0
// ============================================================================
module tpdf_requantizer #(
   parameter int IN_BITS    = 24,
   parameter int OUT_BITS   = 16,
   parameter int NOISE_BITS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NOISE_BITS-1:0] noise,
   input  logic                  dither_en,
   input  logic                  shape_en,
   input  logic [IN_BITS-1:0]    in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [OUT_BITS-1:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int c_D = IN_BITS - OUT_BITS;
   localparam int c_W = IN_BITS + 2;
   localparam logic signed [c_W-1:0] c_QMAX = {{(c_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [c_W-1:0] c_QMIN = {{(c_W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

   logic [IN_BITS-1:0]  r_xa;
   logic [c_D:0]        r_da;
   logic                r_a_valid;
   logic [OUT_BITS-1:0] r_out_data;
   logic                r_out_valid;
   logic [c_D-1:0]      r_frac;

   logic                w_b_can;
   logic                w_a_load;
   logic                w_b_load;
   logic [c_D:0]        w_dither;
   logic [c_D-1:0]      w_fb;
   logic signed [c_W-1:0] w_v;
   logic signed [c_W-1:0] w_q;

   assign w_b_can  = !r_out_valid || out_ready;
   assign in_ready = !r_a_valid || w_b_can;
   assign w_a_load = in_valid && in_ready;
   assign w_b_load = r_a_valid && w_b_can;

   // Difference of two uniform words gives a triangular PDF spanning +/-(2^D-1)
   assign w_dither = dither_en ? ({1'b0, noise[c_D-1:0]} - {1'b0, noise[2*c_D-1:c_D]}) : '0;
   assign w_fb     = shape_en ? r_frac : '0;

   assign w_v = {{(c_W-IN_BITS){r_xa[IN_BITS-1]}}, r_xa}
              + {{(c_W-c_D-1){r_da[c_D]}}, r_da}
              + {{(c_W-c_D){1'b0}}, w_fb};
   assign w_q = w_v >>> c_D;

   generate
      if (NOISE_BITS > 2*c_D) begin : g_noise_unused
         logic w_noise_unused;
         assign w_noise_unused = ^noise[NOISE_BITS-1:2*c_D];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_xa      <= '0;
         r_da      <= '0;
         r_a_valid <= 1'b0;
      end else if (w_a_load) begin
         r_xa      <= in_data;
         r_da      <= w_dither;
         r_a_valid <= 1'b1;
      end else if (w_b_load) begin
         r_a_valid <= 1'b0;
      end
   end

   // Saturation discards the residual so a clipped sample cannot push error forward
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frac      <= '0;
      end else if (w_b_load) begin
         r_out_valid <= 1'b1;
         if (w_q > c_QMAX) begin
            r_out_data <= c_QMAX[OUT_BITS-1:0];
            r_frac     <= '0;
         end else if (w_q < c_QMIN) begin
            r_out_data <= c_QMIN[OUT_BITS-1:0];
            r_frac     <= '0;
         end else begin
            r_out_data <= w_q[OUT_BITS-1:0];
            r_frac     <= shape_en ? w_v[c_D-1:0] : '0;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_tpdf_requantizer.sv
`default_nettype none
// Bench for tpdf_requantizer: directed cases plus randomized traffic against an integer model.
module tb_tpdf_requantizer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] noise;
   logic        dither_en;
   logic        shape_en;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_out   = 0;
   int          m_frac  = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   tpdf_requantizer #(.IN_BITS(24), .OUT_BITS(16), .NOISE_BITS(32)) dut (
      .clk(clk), .rst(rst), .noise(noise), .dither_en(dither_en), .shape_en(shape_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Requantization computed with plain integer arithmetic: floor division, clamp, residual
   function automatic logic [15:0] model(input logic [23:0] x, input logic [31:0] nz,
                                          input logic den, input logic sen);
      int d, v, r, q;
      d = den ? (int'(nz[7:0]) - int'(nz[15:8])) : 0;
      v = int'($signed(x)) + d + (sen ? m_frac : 0);
      r = ((v % 256) + 256) % 256;
      q = (v - r) / 256;
      if (q > 32767) begin
         q = 32767; m_frac = 0;
      end else if (q < -32768) begin
         q = -32768; m_frac = 0;
      end else begin
         m_frac = sen ? r : 0;
      end
      return q[15:0];
   endfunction

   task automatic tick(output bit acc);
      logic [15:0] e;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            check("stream", out_data, e);
         end
      end
      if (acc) exp_q.push_back(model(in_data, noise, dither_en, shape_en));
      @(posedge clk); #1;
   endtask

   task automatic xfer(input string tag, input logic [23:0] d, input logic [31:0] nz,
                       input logic den, input logic sen, input logic [15:0] exp, input bit chk_lat);
      int n;
      in_data = d; noise = nz; dither_en = den; shape_en = sen;
      in_valid = 1'b1; out_ready = 1'b1;
      check({tag, "_rdy"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      noise = $urandom;
      n = 0;
      while (!out_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_vld"}, out_valid, 1);
      if (chk_lat) check({tag, "_lat"}, n, 1);
      check(tag, out_data, exp);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      exp_q.delete();
      m_frac = 0;
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic rand_phase(input logic sen, input int cycles);
      bit acc;
      int n;
      shape_en = sen;
      for (int c = 0; c < cycles; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 5))
            0: in_data = 24'h7FFF00 | 24'($urandom_range(0, 255));
            1: in_data = 24'h800000 | 24'($urandom_range(0, 255));
            default: in_data = 24'($urandom);
         endcase
         noise     = $urandom;
         dither_en = 1'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick(acc);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick(acc);
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      logic [23:0] s[6];
      bit acc;
      int idx, n0;
      rst = 1'b0; noise = '0; dither_en = 1'b0; shape_en = 1'b0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);

      xfer("pass_a", 24'h123456, 32'h0, 1'b0, 1'b0, 16'h1234, 1'b1);
      xfer("pass_b", 24'hFFFF80, 32'h0, 1'b0, 1'b0, 16'hFFFF, 1'b0);

      xfer("dith_zero", 24'h000000, 32'h000010FF, 1'b1, 1'b0, 16'h0000, 1'b0);
      xfer("dith_carry", 24'h000020, 32'h000010FF, 1'b1, 1'b0, 16'h0001, 1'b0);
      xfer("dith_neg", 24'h000000, 32'h0000FF10, 1'b1, 1'b0, 16'hFFFF, 1'b0);

      for (int i = 0; i < 6; i++)
         xfer("shape_on", 24'h000080, $urandom, 1'b0, 1'b1, (i % 2 == 1) ? 16'h0001 : 16'h0000, 1'b0);
      for (int i = 0; i < 4; i++)
         xfer("shape_off", 24'h000080, $urandom, 1'b0, 1'b0, 16'h0000, 1'b0);

      xfer("sat_pre", 24'h000080, 32'h0, 1'b0, 1'b1, 16'h0000, 1'b0);
      xfer("sat_pos", 24'h7FFFFF, 32'h000000FF, 1'b1, 1'b1, 16'h7FFF, 1'b0);
      xfer("sat_clr", 24'h000080, 32'h0, 1'b0, 1'b1, 16'h0000, 1'b0);
      xfer("sat_neg", 24'h800000, 32'h0000FF00, 1'b1, 1'b1, 16'h8000, 1'b0);
      xfer("sat_clr2", 24'h000080, 32'h0, 1'b0, 1'b1, 16'h0000, 1'b0);

      // Backpressure: six samples offered while the output stalls for five cycles
      do_reset();
      shape_en = 1'b0; dither_en = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 6; i++) s[i] = 24'($urandom);
      idx = 0; in_valid = 1'b1; in_data = s[0]; n0 = n_out;
      for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
         if (c == 5) out_ready = 1'b1;
         noise = $urandom;
         tick(acc);
         if (acc) begin
            idx++;
            if (idx < 6) in_data = s[idx];
            else in_valid = 1'b0;
         end
         if (c >= 1 && c <= 4) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", out_data, exp_q[0]);
         end
      end
      check("bp_count", n_out - n0, 6);
      check("bp_left", exp_q.size(), 0);

      do_reset();
      rand_phase(1'b0, 400);
      do_reset();
      rand_phase(1'b1, 400);

      // Asynchronous reset with a stalled output and a nonzero residual
      shape_en = 1'b1; dither_en = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 24'h1234C0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_vld", out_valid, 1);
      check("pre_rst_data", out_data, 16'h1234);
      #2 rst = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_data", out_data, 0);
      check("arst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      exp_q.delete();
      m_frac = 0;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1;
      xfer("post_rst", 24'h123456, 32'h0, 1'b0, 1'b1, 16'h1234, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
